// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART frame command controller.
package uart_cmd_pkg;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_CMD    = 4'd1,
    ST_ADDR   = 4'd2,
    ST_LEN    = 4'd3,
    ST_DATA   = 4'd4,
    ST_CHK    = 4'd5,
    ST_COMMIT = 4'd6,
    ST_RUN    = 4'd7,
    ST_DONE   = 4'd8
  } state_t;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] CMD_RUN   = 8'h52;

  localparam logic [2:0] ERR_NONE    = 3'd0;
  localparam logic [2:0] ERR_BAD_CMD = 3'd1;
  localparam logic [2:0] ERR_BAD_LEN = 3'd2;
  localparam logic [2:0] ERR_CHKSUM  = 3'd3;
  localparam logic [2:0] ERR_TIMEOUT = 3'd4;

  // States in which the receiver byte stream is being consumed.
  function automatic logic is_rx_state(input state_t s);
    return (s == ST_IDLE) || (s == ST_CMD) || (s == ST_ADDR) ||
           (s == ST_LEN) || (s == ST_DATA) || (s == ST_CHK);
  endfunction

endpackage

// File: rtl/uart_cmd_buf.sv
// Payload buffer: DEPTH x 8 registers, synchronous write, asynchronous read.
module uart_cmd_buf #(
  parameter int DEPTH = 16,
  parameter int IW    = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [IW-1:0] wr_idx,
  input  logic [7:0]    wr_data,
  input  logic [IW-1:0] rd_idx,
  output logic [7:0]    rd_data
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en && (int'(wr_idx) < DEPTH)) begin
      mem[wr_idx] <= wr_data;
    end
  end

  // Out-of-range indices read as zero (only reachable past the last commit).
  assign rd_data = (int'(rd_idx) < DEPTH) ? mem[rd_idx] : 8'h00;

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Frame parser / loader: sync hunt, checksum, buffered memory commit, CPU start.
// rx handshake: a byte transfers on any cycle where rx_data_valid && rx_data_ready.
module uart_cmd_ctrl
  import uart_cmd_pkg::*;
#(
  parameter int CLK_FRE    = 50,
  parameter int TIMEOUT_US = 1000,
  parameter int MAX_LEN    = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_data_valid,
  output logic       rx_data_ready,
  output logic       mem_wr_en,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  input  logic       mem_ready,
  output logic       cpu_start,
  output logic [7:0] start_addr,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [2:0] err_code,
  output logic       busy,
  output state_t     state_dbg
);

  localparam int         IW          = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [7:0] MAX_LEN_B   = 8'(MAX_LEN);
  localparam logic [31:0] TIMEOUT_CYC = 32'(CLK_FRE * TIMEOUT_US);

  state_t      state, state_nx;
  logic [7:0]  cmd, addr, len, sum, idx, cidx;
  logic [31:0] tcnt;
  logic [7:0]  buf_rd;
  logic        accept, timeout_hit, err_fire;
  logic [2:0]  err_nx;

  assign accept    = rx_data_valid && rx_data_ready;
  assign state_dbg = state;
  assign timeout_hit = (state != ST_IDLE) && is_rx_state(state) && !accept &&
                       (tcnt == TIMEOUT_CYC - 32'd1);

  uart_cmd_buf #(.DEPTH(MAX_LEN), .IW(IW)) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (state == ST_DATA && accept),
    .wr_idx  (idx[IW-1:0]),
    .wr_data (rx_data),
    .rd_idx  (cidx[IW-1:0]),
    .rd_data (buf_rd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    err_fire = 1'b0;
    err_nx   = ERR_NONE;
    case (state)
      ST_IDLE: if (accept && rx_data == SYNC_BYTE) state_nx = ST_CMD;
      ST_CMD: if (accept) begin
        if (rx_data == CMD_WRITE || rx_data == CMD_RUN) state_nx = ST_ADDR;
        else begin err_fire = 1'b1; err_nx = ERR_BAD_CMD; end
      end
      ST_ADDR: if (accept) state_nx = ST_LEN;
      ST_LEN: if (accept) begin
        if (cmd == CMD_WRITE) begin
          if (rx_data != 8'd0 && rx_data <= MAX_LEN_B) state_nx = ST_DATA;
          else begin err_fire = 1'b1; err_nx = ERR_BAD_LEN; end
        end else begin
          if (rx_data == 8'd0) state_nx = ST_CHK;
          else begin err_fire = 1'b1; err_nx = ERR_BAD_LEN; end
        end
      end
      ST_DATA: if (accept && idx == len - 8'd1) state_nx = ST_CHK;
      ST_CHK: if (accept) begin
        if (rx_data != sum) begin err_fire = 1'b1; err_nx = ERR_CHKSUM; end
        else if (cmd == CMD_WRITE) state_nx = ST_COMMIT;
        else state_nx = ST_RUN;
      end
      // Idle gap after each acknowledged write; leave once all are done.
      ST_COMMIT: if (!mem_wr_en && cidx == len) state_nx = ST_DONE;
      ST_RUN:  state_nx = ST_DONE;
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
    if (timeout_hit) begin
      err_fire = 1'b1;
      err_nx   = ERR_TIMEOUT;
    end
    if (err_fire) state_nx = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data_ready <= 1'b0;
      busy          <= 1'b0;
      mem_wr_en     <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      cpu_start     <= 1'b0;
      start_addr    <= '0;
      frame_ok      <= 1'b0;
      frame_err     <= 1'b0;
      err_code      <= ERR_NONE;
      cmd           <= '0;
      addr          <= '0;
      len           <= '0;
      sum           <= '0;
      idx           <= '0;
      cidx          <= '0;
      tcnt          <= '0;
    end else begin
      cpu_start     <= 1'b0;
      frame_ok      <= 1'b0;
      frame_err     <= 1'b0;
      rx_data_ready <= is_rx_state(state_nx);
      busy          <= (state_nx != ST_IDLE);

      if (accept || state == ST_IDLE) tcnt <= '0;
      else if (is_rx_state(state))    tcnt <= tcnt + 32'd1;

      if (accept) begin
        case (state)
          ST_IDLE: if (rx_data == SYNC_BYTE) begin
            sum  <= '0;
            idx  <= '0;
            cidx <= '0;
          end
          ST_CMD:  begin cmd  <= rx_data; sum <= sum + rx_data; end
          ST_ADDR: begin addr <= rx_data; sum <= sum + rx_data; end
          ST_LEN:  begin len  <= rx_data; sum <= sum + rx_data; end
          ST_DATA: begin idx  <= idx + 8'd1; sum <= sum + rx_data; end
          default: ;
        endcase
      end

      if (state == ST_CHK && state_nx == ST_COMMIT) begin
        mem_wr_en <= 1'b1;
        mem_addr  <= addr;
        mem_wdata <= buf_rd;
      end
      if (state == ST_CHK && state_nx == ST_RUN) begin
        cpu_start  <= 1'b1;
        start_addr <= addr;
      end

      if (state == ST_COMMIT) begin
        if (mem_wr_en && mem_ready) begin
          mem_wr_en <= 1'b0;
          cidx      <= cidx + 8'd1;
        end else if (!mem_wr_en && cidx != len) begin
          mem_wr_en <= 1'b1;
          mem_addr  <= addr + cidx;
          mem_wdata <= buf_rd;
        end
      end

      if (state_nx == ST_DONE && state != ST_DONE) begin
        frame_ok <= 1'b1;
        err_code <= ERR_NONE;
      end
      if (err_fire) begin
        frame_err <= 1'b1;
        err_code  <= err_nx;
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Directed bench for uart_cmd_ctrl: frame vector table plus timing/corner sequences.
module tb_uart_cmd_ctrl;
  import uart_cmd_pkg::*;

  localparam int TO_US = 20;   // with CLK_FRE=1 the timeout is 20 cycles

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_data = '0;
  logic       rx_data_valid = 1'b0;
  logic       rx_data_ready;
  logic       mem_wr_en;
  logic [7:0] mem_addr, mem_wdata;
  logic       mem_ready = 1'b0;
  logic       cpu_start;
  logic [7:0] start_addr;
  logic       frame_ok, frame_err;
  logic [2:0] err_code;
  logic       busy;
  state_t     state_dbg;

  uart_cmd_ctrl #(.CLK_FRE(1), .TIMEOUT_US(TO_US), .MAX_LEN(16)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_data_valid(rx_data_valid),
    .rx_data_ready(rx_data_ready), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .cpu_start(cpu_start),
    .start_addr(start_addr), .frame_ok(frame_ok), .frame_err(frame_err),
    .err_code(err_code), .busy(busy), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- memory responder ----------------
  int ready_lat = 0;
  int wait_cnt  = 0;
  always @(posedge clk) begin
    #1;
    if (ready_lat == 0) mem_ready = 1'b1;
    else if (mem_wr_en && !mem_ready) begin
      if (wait_cnt == ready_lat) begin mem_ready = 1'b1; wait_cnt = 0; end
      else wait_cnt++;
    end else mem_ready = 1'b0;
  end

  // ---------------- monitor / scoreboard ----------------
  logic [15:0] exp_q[$];
  int n_ok = 0, n_errp = 0, n_cpu = 0, n_wr = 0;
  logic       prev_pend = 1'b0;
  logic [15:0] prev_wr = '0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_ok)  n_ok++;
      if (frame_err) n_errp++;
      if (cpu_start) n_cpu++;
      if (state_dbg == ST_COMMIT) check("rdy_low_commit", 32'(rx_data_ready), 32'd0);
      if (prev_pend && mem_wr_en) check("wr_stable", 32'({mem_addr, mem_wdata}), 32'(prev_wr));
      if (mem_wr_en && mem_ready) begin
        n_wr++;
        if (exp_q.size() == 0) check("unexpected_wr", 32'({mem_addr, mem_wdata}), 32'hFFFF_FFFF);
        else check("wr_addr_data", 32'({mem_addr, mem_wdata}), 32'(exp_q.pop_front()));
      end
    end
    prev_pend = mem_wr_en && !mem_ready && rst_n;
    prev_wr   = {mem_addr, mem_wdata};
  end

  // ---------------- driver ----------------
  task automatic send_byte(input logic [7:0] b);
    int n;
    rx_data = b;
    rx_data_valid = 1'b1;
    n = 0;
    while (1) begin
      @(negedge clk);
      if (rx_data_ready) break;
      n++;
      if (n > 200) begin
        check("rx_ready_timeout", 32'd0, 32'd1);
        break;
      end
    end
    @(posedge clk);
    #1;
    rx_data_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_counts();
    n_ok = 0; n_errp = 0; n_cpu = 0; n_wr = 0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [63:0] bytes;   // first byte in [63:56]
    int          n;
    int          lat;
    int          ok;
    int          err;
    logic [2:0]  code;
    int          cpu;
    logic [7:0]  saddr;
    int          nwr;
    logic [31:0] wr;      // {addr0,data0,addr1,data1}
  } vec_t;

  vec_t vecs[8];
  logic [7:0] exp_saddr = 8'h00;

  initial begin
    vecs[0] = '{64'hA557_1002_AABB_CE00, 7, 0, 1, 0, ERR_NONE,    0, 8'h00, 2, 32'h10AA_11BB};
    vecs[1] = '{64'hA552_4000_9200_0000, 5, 0, 1, 0, ERR_NONE,    1, 8'h40, 0, 32'h0};
    vecs[2] = '{64'hA557_1002_AABB_CF00, 7, 0, 0, 1, ERR_CHKSUM,  0, 8'h00, 0, 32'h0};
    vecs[3] = '{64'hA557_FF02_0102_5B00, 7, 5, 1, 0, ERR_NONE,    0, 8'h00, 2, 32'hFF01_0002};
    vecs[4] = '{64'hA533_0000_0000_0000, 2, 0, 0, 1, ERR_BAD_CMD, 0, 8'h00, 0, 32'h0};
    vecs[5] = '{64'hA557_0000_0000_0000, 4, 0, 0, 1, ERR_BAD_LEN, 0, 8'h00, 0, 32'h0};
    vecs[6] = '{64'hA557_0011_0000_0000, 4, 0, 0, 1, ERR_BAD_LEN, 0, 8'h00, 0, 32'h0};
    vecs[7] = '{64'h00FF_12A5_5207_0059, 8, 0, 1, 0, ERR_NONE,    1, 8'h07, 0, 32'h0};

    // reset state
    #2;
    check("rst_rx_ready", 32'(rx_data_ready), 32'd0);
    check("rst_outputs", 32'({mem_wr_en, mem_addr, mem_wdata, cpu_start, start_addr,
                              frame_ok, frame_err, err_code, busy}), 32'd0);
    check("rst_state", 32'(state_dbg), 32'(ST_IDLE));
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst", 32'(rx_data_ready), 32'd1);
    @(posedge clk); #1;

    foreach (vecs[k]) begin
      int w;
      vec_t v;
      v = vecs[k];
      clear_counts();
      ready_lat = v.lat;
      if (v.nwr >= 1) exp_q.push_back(v.wr[31:16]);
      if (v.nwr >= 2) exp_q.push_back(v.wr[15:0]);
      if (v.cpu != 0) exp_saddr = v.saddr;
      for (int i = 0; i < v.n; i++) send_byte(v.bytes[63 - 8*i -: 8]);
      w = 0;
      while (n_ok + n_errp == 0 && w < 80) begin @(negedge clk); w++; end
      if (w >= 80) check("frame_end_timeout", 32'd0, 32'd1);
      idle(4);
      check($sformatf("v%0d_ok", k), 32'(n_ok), 32'(v.ok));
      check($sformatf("v%0d_err", k), 32'(n_errp), 32'(v.err));
      check($sformatf("v%0d_code", k), 32'(err_code), 32'(v.code));
      check($sformatf("v%0d_cpu", k), 32'(n_cpu), 32'(v.cpu));
      check($sformatf("v%0d_saddr", k), 32'(start_addr), 32'(exp_saddr));
      check($sformatf("v%0d_nwr", k), 32'(n_wr), 32'(v.nwr));
      check($sformatf("v%0d_q_empty", k), 32'(exp_q.size()), 32'd0);
      check($sformatf("v%0d_idle", k), 32'({busy, rx_data_ready}), 32'b01);
      exp_q.delete();
    end
    ready_lat = 0;

    // max-length write: first write 1 cycle after CHK accept, frame_ok at 2N+1
    begin
      int k;
      clear_counts();
      send_byte(8'hA5); send_byte(8'h57); send_byte(8'h30); send_byte(8'h10);
      for (int i = 0; i < 16; i++) begin
        send_byte(8'(i + 1));
        exp_q.push_back({8'(8'h30 + i), 8'(i + 1)});
      end
      send_byte(8'h1F);
      @(negedge clk);
      check("max_wr_en_first", 32'(mem_wr_en), 32'd1);
      k = 1;
      while (!frame_ok && k < 100) begin @(negedge clk); k++; end
      check("max_ok_latency", 32'(k), 32'd33);
      idle(2);
      check("max_nwr", 32'(n_wr), 32'd16);
      check("max_q_empty", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end

    // run timing: cpu_start right after CHK, frame_ok one cycle later
    clear_counts();
    send_byte(8'hA5); send_byte(8'h52); send_byte(8'h80); send_byte(8'h00); send_byte(8'hD2);
    @(negedge clk);
    check("run_cpu_start", 32'({cpu_start, frame_ok}), 32'b10);
    check("run_saddr", 32'(start_addr), 32'h80);
    @(negedge clk);
    check("run_frame_ok", 32'({cpu_start, frame_ok}), 32'b01);
    idle(2);

    // error timing: frame_err the cycle after the offending LEN byte
    send_byte(8'hA5); send_byte(8'h57); send_byte(8'h00); send_byte(8'h11);
    @(negedge clk);
    check("len_err_timing", 32'({frame_err, err_code}), 32'({1'b1, ERR_BAD_LEN}));
    idle(2);

    // inter-byte timeout
    begin
      int k;
      clear_counts();
      send_byte(8'hA5); send_byte(8'h57);
      k = 1;
      @(negedge clk);
      while (!frame_err && k < 60) begin @(negedge clk); k++; end
      check("to_window", 32'(k >= TO_US && k <= TO_US + 2), 32'd1);
      check("to_code", 32'(err_code), 32'(ERR_TIMEOUT));
      idle(2);
      check("to_idle", 32'(state_dbg), 32'(ST_IDLE));
    end

    // reset in the middle of COMMIT
    clear_counts();
    ready_lat = 5;
    send_byte(8'hA5); send_byte(8'h57); send_byte(8'h20); send_byte(8'h01);
    send_byte(8'h33); send_byte(8'hAB);
    @(negedge clk);
    check("commit_pending", 32'({mem_wr_en, rx_data_ready}), 32'b10);
    check("commit_state", 32'(state_dbg), 32'(ST_COMMIT));
    rst_n = 1'b0;
    #1;
    check("rst_abort_wr", 32'({mem_wr_en, busy}), 32'd0);
    check("rst_abort_state", 32'(state_dbg), 32'(ST_IDLE));
    @(negedge clk); rst_n = 1'b1;
    ready_lat = 0;
    idle(8);
    check("rst_abort_nwr", 32'(n_wr), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation bound reached");
    $fatal(1, "global timeout");
  end

endmodule
